// File: rtl/seg_arbiter.sv
// Round-robin arbiter that time-shares a 7-segment display among four requesters (d, A, E, F).
// Each winner is shown for DWELL cycles, then one blank separator cycle.
`timescale 1ns/1ps
module seg_arbiter #(
    parameter int unsigned DWELL = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [6:0] segments,
    output logic       busy,
    output logic       slot_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 32'd1);
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_ptr, w_ptr_nxt;
    logic [1:0] r_gidx, w_gidx_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [3:0] r_grant, w_grant_nxt;
    logic [6:0] r_seg, w_seg_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_done, w_done_nxt;
    logic [1:0] w_win;

    // First set request bit at or after p, wrapping 3 -> 0.
    function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = p;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end else begin
                res   = res;
                found = found;
            end
        end
        return res;
    endfunction

    // Active-low glyph for each requester, bit order abc_defg.
    function automatic logic [6:0] seg_pattern(input logic [1:0] idx);
        logic [6:0] pat;
        case (idx)
            2'd3:    pat = 7'b100_0010;
            2'd2:    pat = 7'b000_1000;
            2'd1:    pat = 7'b011_0000;
            2'd0:    pat = 7'b011_1000;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    function automatic logic [3:0] one_hot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Winner search from the round-robin pointer.
    always_comb begin
        w_win = pick_winner(req, r_ptr);
    end

    // Next-state and next-output decode; outputs are registered alongside the state.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gidx_nxt  = r_gidx;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = r_grant;
        w_seg_nxt   = r_seg;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (req != 4'b0000) begin
                    w_state_nxt = ST_SHOW;
                    w_gidx_nxt  = w_win;
                    w_cnt_nxt   = DWELL_M1;
                    w_grant_nxt = one_hot(w_win);
                    w_seg_nxt   = seg_pattern(w_win);
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                    w_grant_nxt = 4'b0000;
                    w_seg_nxt   = SEG_BLANK;
                    w_busy_nxt  = 1'b0;
                end
            end
            ST_SHOW: begin
                // A withdrawn request ends the slot even if the dwell count is also exhausted.
                if (!req[r_gidx] || (r_cnt == 8'd0)) begin
                    w_state_nxt = ST_GAP;
                    w_ptr_nxt   = r_gidx + 2'd1;
                    w_cnt_nxt   = 8'd0;
                    w_grant_nxt = 4'b0000;
                    w_seg_nxt   = SEG_BLANK;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = 2'd0;
                w_cnt_nxt   = 8'd0;
                w_grant_nxt = 4'b0000;
                w_seg_nxt   = SEG_BLANK;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_gidx  <= 2'd0;
            r_cnt   <= 8'd0;
            r_grant <= 4'b0000;
            r_seg   <= SEG_BLANK;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gidx  <= w_gidx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grant <= w_grant_nxt;
            r_seg   <= w_seg_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign grant     = r_grant;
    assign segments  = r_seg;
    assign busy      = r_busy;
    assign slot_done = r_done;

endmodule
